data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/mem_pkg.sv | 33 +++
 rtl/dmem_array.sv | 34 +++
 rtl/data_memory_ctrl.sv | 119 +++++++++++
 tb/tb_data_memory_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access size encodings, controller state type and load lane extraction
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    // Pick the addressed byte/half out of a stored word and widen it to 32 bits.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        zero_ext
    );
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        logic [31:0] result;
        sel_byte = word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: result = zero_ext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: result = zero_ext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default:   result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-organised data RAM with byte-enable write and registered read-first port
module dmem_array #(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              re,
    output logic [31:0]       rdata
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx;

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    // Read sees the pre-write contents when a read and write hit the same word.
    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem[addr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MEM-stage load/store controller; DMEM_MISALIGN_TRAP_EN enables misaligned-access trapping
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [31:0] alu_out,
    output logic        misalign
);

    state_t      state;
    logic [1:0]  ld_lane;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic        accept;
    logic        suppress;
    logic        do_store;
    logic        do_load;
    logic [1:0]  lane;
    logic [3:0]  byte_en;
    logic [31:0] store_data;
    logic [31:0] array_q;

    assign accept = req_valid && (state == IDLE) && !reset;

    // Natural alignment: halves drop addr[0], words (and the reserved size) drop addr[1:0].
    always_comb begin
        lane = req_addr[1:0];
        if (req_size == SIZE_HALF) begin
            lane[0] = 1'b0;
        end else if (req_size != SIZE_BYTE) begin
            lane = 2'b00;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign suppress = (lane != req_addr[1:0]);
`else
    assign suppress = 1'b0;
`endif

    assign do_store = accept && req_write && !suppress;
    assign do_load  = accept && !req_write && !suppress;
    assign stall    = do_load;

    always_comb begin
        case (req_size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    dmem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .clock (clock),
        .we    (do_store),
        .be    (byte_en),
        .addr  (req_addr[ADDR_W+1:2]),
        .wdata (store_data),
        .re    (do_load),
        .rdata (array_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            alu_out     <= 32'h0;
            misalign    <= 1'b0;
            ld_lane     <= 2'b00;
            ld_size     <= SIZE_WORD;
            ld_unsigned <= 1'b0;
        end else begin
            misalign <= accept && suppress;
            if (accept) begin
                alu_out <= req_addr;
            end
            case (state)
                IDLE: begin
                    if (do_load) begin
                        state       <= LOAD_WAIT;
                        ld_lane     <= lane;
                        ld_size     <= req_size;
                        ld_unsigned <= req_unsigned;
                    end
                end
                LOAD_WAIT: state <= IDLE;
            endcase
        end
    end

    // A reset arriving during LOAD_WAIT aborts the load, so it also masks the result pulse.
    assign rdata_valid = (state == LOAD_WAIT) && !reset;
    assign rdata       = rdata_valid ? extend_load(array_q, ld_size, ld_lane, ld_unsigned) : 32'h0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl against a byte-addressed reference model
module tb_data_memory_ctrl;

    localparam int ADDR_W     = 10;
    localparam int NBYTES_MEM = 4 << ADDR_W;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [31:0] alu_out;
    logic        misalign;

    always #5 clock = ~clock;

    data_memory_ctrl #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .alu_out      (alu_out),
        .misalign     (misalign)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  model [NBYTES_MEM];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % size_bytes(sz)) != 0;
    endfunction

    function automatic int eff_addr(input logic [31:0] a, input logic [1:0] sz);
        int e;
        e = int'(a & 32'(NBYTES_MEM - 1));
        return e - (e % size_bytes(sz));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int          nb;
        int          e;
        logic [31:0] v;
        nb = size_bytes(sz);
        e  = eff_addr(a, sz);
        v  = 32'h0;
        for (int i = 0; i < nb; i++) begin
            v = v | (32'(model[e + i]) << (8 * i));
        end
        if (!uns && nb < 4 && v[8*nb-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int nb;
        int e;
        nb = size_bytes(sz);
        e  = eff_addr(a, sz);
        for (int i = 0; i < nb; i++) begin
            model[e + i] = d[8*i +: 8];
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
    endtask

    // Called at posedge+1 with the controller idle; returns at posedge+1 with it idle again.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] d, input logic chk, input logic [31:0] exp, input string name);
        bit          mis;
        bit          ld;
        bit          st;
        logic [31:0] exp_ld;
        mis    = TRAP && is_mis(a, sz);
        ld     = !w && !mis;
        st     = w && !mis;
        exp_ld = model_load(a, sz, uns);
        drive(w, sz, uns, a, d);
        @(negedge clock);
        check({name, ".stall"}, 32'(stall), 32'(ld));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (st) model_store(a, sz, d);
        @(negedge clock);
        check({name, ".alu_out"}, alu_out, a);
        check({name, ".misalign"}, 32'(misalign), 32'(mis));
        check({name, ".rdata_valid"}, 32'(rdata_valid), 32'(ld));
        check({name, ".stall_wait"}, 32'(stall), 32'h0);
        if (ld) check({name, ".rdata"}, rdata, exp_ld);
        if (ld && chk) check({name, ".rdata_table"}, rdata, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] d, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = d; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NBYTES_MEM; i++) model[i] = 8'h00;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        add_vec(1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0);
        add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF);
        add_vec(1'b1, 2'd0, 1'b0, 32'h13,   32'h12345680, 1'b0, 32'h0);
        add_vec(1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        1'b1, 32'hFFFFFF80);
        add_vec(1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        1'b1, 32'h00000080);
        add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b1, 32'h80ADBEEF);
        add_vec(1'b1, 2'd1, 1'b0, 32'h22,   32'hABCD1234, 1'b0, 32'h0);
        add_vec(1'b0, 2'd1, 1'b1, 32'h22,   32'h0,        1'b1, 32'h00001234);
        add_vec(1'b0, 2'd2, 1'b0, 32'h1020, 32'h0,        1'b1, 32'h12340000);
        add_vec(1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        1'b1, 32'hFFFF80AD);
        add_vec(1'b0, 2'd2, 1'b0, 32'h11,   32'h0,        1'b1, 32'h80ADBEEF);
        add_vec(1'b1, 2'd1, 1'b0, 32'h21,   32'h00005555, 1'b0, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add_vec(1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        1'b1, 32'h12340000);
`else
        add_vec(1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        1'b1, 32'h12345555);
`endif
        add_vec(1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        1'b1, 32'h80ADBEEF);
        add_vec(1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        1'b1, 32'hFFFFFFEF);
        add_vec(1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        1'b1, 32'h000080AD);
        add_vec(1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        1'b1, 32'h000000BE);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.stall", 32'(stall), 32'h0);
        check("reset.rdata", rdata, 32'h0);
        check("reset.rdata_valid", 32'(rdata_valid), 32'h0);
        check("reset.alu_out", alu_out, 32'h0);
        check("reset.misalign", 32'(misalign), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // store then load of the same word on consecutive cycles; request during LOAD_WAIT ignored
        drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
        @(negedge clock);
        check("b2b.store_stall", 32'(stall), 32'h0);
        @(posedge clock);
        #1;
        model_store(32'h40, 2'd2, 32'hCAFEF00D);
        drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        @(negedge clock);
        check("b2b.load_stall", 32'(stall), 32'h1);
        @(posedge clock);
        #1;
        drive(1'b1, 2'd2, 1'b0, 32'h44, 32'h11111111);
        @(negedge clock);
        check("b2b.wait_stall", 32'(stall), 32'h0);
        check("b2b.rdata_valid", 32'(rdata_valid), 32'h1);
        check("b2b.rdata", rdata, 32'hCAFEF00D);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("b2b.alu_out_hold", alu_out, 32'h40);
        check("b2b.no_second_valid", 32'(rdata_valid), 32'h0);
        @(posedge clock);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1, 32'h0, "b2b.ignored_store");
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, "b2b.reload");

        // reset while a load is in LOAD_WAIT
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(negedge clock);
        check("abort.stall", 32'(stall), 32'h1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("abort.rdata_valid", 32'(rdata_valid), 32'h0);
        check("abort.stall_wait", 32'(stall), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort.rdata_valid_after", 32'(rdata_valid), 32'h0);
        check("abort.alu_out", alu_out, 32'h0);
        @(posedge clock);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, "abort.reload");

        // requests presented while reset is high must be ignored
        reset = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h77777777);
        @(negedge clock);
        check("rstreq.store_stall", 32'(stall), 32'h0);
        @(posedge clock);
        #1;
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(negedge clock);
        check("rstreq.load_stall", 32'(stall), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("rstreq.rdata_valid", 32'(rdata_valid), 32'h0);
        check("rstreq.alu_out", alu_out, 32'h0);
        @(posedge clock);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, "rstreq.reload");

        // random traffic over a small window, random upper address bits exercise wrap-around
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'b0, 32'h0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
